zorro2_autoconfig_chain: RTL and testbench

ZORRO2_AUTOCONFIG_CHAIN -- requirements
Module: zorro2_autoconfig_chain

---
 rtl/zorro2_autoconfig_chain.sv | 221 ++++++++++++++++++++++
 tb/tb_zorro2_autoconfig_chain.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zorro2_autoconfig_chain.sv
// -----------------------------------------------------------------------------
// zorro2_autoconfig_chain
//
// Presents NUM_BOARDS logical Zorro II boards one after another in the
// autoconfig space at $E8xxxx. The board currently visible is CUR_IDX. Once the
// host either assigns a base address (write to $48) or shuts the board up
// (write to $4C), the block waits for the bus to be released. It then moves on
// to the next board. After the last board it drives CFGOUT_n low and stops
// decoding autoconfig accesses.
//
// Ports
//   C7M           bus clock, rising edge active
//   RESET_n       asynchronous active-low reset
//   CFGIN_n       chain input; low enables configuration of this card
//   AS_n/DS_n/RW_n Zorro II address strobe, data strobe, read/write
//   A_HIGH[7:0]   address bits 23:16
//   A_LOW[5:0]    address bits 6:1 (byte offset = {A_LOW, 1'b0})
//   D_IN[3:0]     data bits 15:12 during writes
//   D_OUT[3:0]    registered read nibble (one clock latency)
//   D_OE[3:0]     combinational data drive enable
//   BASE          assigned base A23:A16, board i in [8*i +: 8]
//   CONFIGURED_n  per-board configured flag, active-low
//   SHUTUP_n      per-board shut-up flag, active-low
//   CFGOUT_n      chain output; low once every board is done
//   CUR_IDX[1:0]  index of the board currently being configured
// -----------------------------------------------------------------------------
module zorro2_autoconfig_chain #(
  parameter int                        NUM_BOARDS  = 2,
  parameter logic [15:0]               MFG_ID      = 16'h082C,
  parameter logic [31:0]               SERIAL      = 32'h0,
  parameter logic [8*NUM_BOARDS-1:0]   PROD_IDS    = {8'd6, 8'd8},
  parameter logic [3*NUM_BOARDS-1:0]   SIZE_CODES  = {3'b001, 3'b000},
  parameter logic [NUM_BOARDS-1:0]     LINK_MEM    = 2'b01,
  parameter logic [NUM_BOARDS-1:0]     ROM_VALID   = 2'b10,
  parameter logic [16*NUM_BOARDS-1:0]  ROM_VECTORS = {16'h0001, 16'h0000}
) (
  input  logic                      C7M,
  input  logic                      RESET_n,
  input  logic                      CFGIN_n,
  input  logic                      AS_n,
  input  logic                      DS_n,
  input  logic                      RW_n,
  input  logic [7:0]                A_HIGH,
  input  logic [5:0]                A_LOW,
  input  logic [3:0]                D_IN,
  output logic [3:0]                D_OUT,
  output logic [3:0]                D_OE,
  output logic [8*NUM_BOARDS-1:0]   BASE,
  output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
  output logic [NUM_BOARDS-1:0]     SHUTUP_n,
  output logic                      CFGOUT_n,
  output logic [1:0]                CUR_IDX
);

  localparam logic [1:0] LAST_IDX    = 2'(NUM_BOARDS - 1);
  // Word offsets (A6:A1) of the writable registers: bytes $48, $4A, $4C.
  localparam logic [5:0] OFF_BASE_HI = 6'd36;
  localparam logic [5:0] OFF_BASE_LO = 6'd37;
  localparam logic [5:0] OFF_SHUTUP  = 6'd38;

  typedef enum logic [1:0] {
    ST_CFG  = 2'd0,
    ST_ADV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_reg;
  logic [1:0] cur_idx_reg;
  logic       cfgout_n_reg;
  logic [3:0] d_out_reg;

  // Per-slot read nibble for the current A_LOW and per-slot done flag. Slots
  // beyond NUM_BOARDS are tied off so CUR_IDX can index the full 2-bit range.
  logic [3:0][3:0] nibble_tbl;
  logic [3:0]      done_vec;

  logic ac_access;
  logic rd_strobe;
  logic wr_fire;
  logic becomes_done;

  // Autoconfig ROM contents for one board. Apart from bytes $00/$02 and
  // the fixed $40/$42 zeros, the host expects these nibbles inverted.
  function automatic logic [3:0] cfg_nibble(
    input logic [5:0]  a,
    input logic        link,
    input logic        rom_ok,
    input logic        chain,
    input logic [2:0]  size,
    input logic [7:0]  prod,
    input logic [15:0] rom_vec
  );
    logic [3:0] nib;
    case (a)
      6'd0:    nib = {2'b11, link, rom_ok};
      6'd1:    nib = {chain, size};
      6'd2:    nib = ~prod[7:4];
      6'd3:    nib = ~prod[3:0];
      6'd4:    nib = ~4'b1100;
      6'd5:    nib = ~4'b0000;
      6'd8:    nib = ~MFG_ID[15:12];
      6'd9:    nib = ~MFG_ID[11:8];
      6'd10:   nib = ~MFG_ID[7:4];
      6'd11:   nib = ~MFG_ID[3:0];
      6'd12:   nib = ~SERIAL[31:28];
      6'd13:   nib = ~SERIAL[27:24];
      6'd14:   nib = ~SERIAL[23:20];
      6'd15:   nib = ~SERIAL[19:16];
      6'd16:   nib = ~SERIAL[15:12];
      6'd17:   nib = ~SERIAL[11:8];
      6'd18:   nib = ~SERIAL[7:4];
      6'd19:   nib = ~SERIAL[3:0];
      6'd20:   nib = ~rom_vec[15:12];
      6'd21:   nib = ~rom_vec[11:8];
      6'd22:   nib = ~rom_vec[7:4];
      6'd23:   nib = ~rom_vec[3:0];
      6'd32,
      6'd33:   nib = 4'h0;
      default: nib = 4'hF;
    endcase
    return nib;
  endfunction

  // Once CFGOUT_n is low the card stops responding at $E8.
  assign ac_access = !CFGIN_n && cfgout_n_reg && (A_HIGH == 8'hE8) && !AS_n;
  assign rd_strobe = ac_access && RW_n && !DS_n;
  assign wr_fire   = ac_access && !RW_n && !DS_n && !done_vec[cur_idx_reg];
  assign becomes_done = wr_fire &&
                        ((A_LOW == OFF_BASE_HI) || (A_LOW == OFF_SHUTUP));

  assign D_OE     = rd_strobe ? 4'hF : 4'h0;
  assign D_OUT    = d_out_reg;
  assign CFGOUT_n = cfgout_n_reg;
  assign CUR_IDX  = cur_idx_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < NUM_BOARDS) begin : g_board
        logic [7:0] base_reg;
        logic       configured_n_reg;
        logic       shutup_n_reg;
        logic       board_wr;

        assign board_wr = wr_fire && (cur_idx_reg == 2'(gi));

        always_ff @(posedge C7M or negedge RESET_n) begin
          if (!RESET_n) begin
            base_reg         <= 8'h00;
            configured_n_reg <= 1'b1;
            shutup_n_reg     <= 1'b1;
          end else if (board_wr) begin
            case (A_LOW)
              OFF_BASE_LO: base_reg[3:0] <= D_IN;
              OFF_BASE_HI: begin
                base_reg[7:4]    <= D_IN;
                configured_n_reg <= 1'b0;
              end
              OFF_SHUTUP:  shutup_n_reg <= 1'b0;
              default: ;
            endcase
          end
        end

        assign BASE[8*gi +: 8]  = base_reg;
        assign CONFIGURED_n[gi] = configured_n_reg;
        assign SHUTUP_n[gi]     = shutup_n_reg;
        assign done_vec[gi]     = !configured_n_reg || !shutup_n_reg;
        assign nibble_tbl[gi]   = cfg_nibble(
          A_LOW,
          LINK_MEM[gi],
          ROM_VALID[gi],
          1'(gi < NUM_BOARDS - 1),
          SIZE_CODES[3*gi +: 3],
          PROD_IDS[8*gi +: 8],
          ROM_VALID[gi] ? ROM_VECTORS[16*gi +: 16] : 16'h0000
        );
      end else begin : g_unused
        assign done_vec[gi]   = 1'b1;
        assign nibble_tbl[gi] = 4'hF;
      end
    end
  endgenerate

  // Sequencing FSM. A board moves to ADV on the same edge as the write that
  // completes it. The pointer only moves once AS_n is seen high, so the
  // chain output never changes in the middle of a bus cycle.
  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg    <= ST_CFG;
      cur_idx_reg  <= 2'd0;
      cfgout_n_reg <= 1'b1;
      d_out_reg    <= 4'hF;
    end else begin
      if (rd_strobe) begin
        d_out_reg <= nibble_tbl[cur_idx_reg];
      end
      case (state_reg)
        ST_CFG: begin
          if (becomes_done) begin
            state_reg <= ST_ADV;
          end
        end
        ST_ADV: begin
          // Held while the chain input is inactive so outputs stay frozen.
          if (!CFGIN_n && AS_n) begin
            if (cur_idx_reg < LAST_IDX) begin
              cur_idx_reg <= cur_idx_reg + 2'd1;
              state_reg   <= ST_CFG;
            end else begin
              state_reg    <= ST_DONE;
              cfgout_n_reg <= 1'b0;
            end
          end
        end
        ST_DONE: ;
        default: state_reg <= ST_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_zorro2_autoconfig_chain.sv
// -----------------------------------------------------------------------------
// tb_zorro2_autoconfig_chain
//
// Directed bench for zorro2_autoconfig_chain with default parameters. A
// board-level model tracks the expected autoconfig state. A compare process
// checks every DUT output against the model on each falling clock edge.
// Directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_zorro2_autoconfig_chain;

  localparam int NB = 2;
  localparam logic [15:0] MFG    = 16'h082C;
  localparam logic [31:0] SER    = 32'h0;
  localparam logic [7:0]  PROD   [NB] = '{8'd8, 8'd6};
  localparam logic [2:0]  SIZE   [NB] = '{3'b000, 3'b001};
  localparam logic        LINK   [NB] = '{1'b1, 1'b0};
  localparam logic        ROMV   [NB] = '{1'b0, 1'b1};
  localparam logic [15:0] ROMVEC [NB] = '{16'h0000, 16'h0001};

  logic        C7M = 1'b0;
  logic        RESET_n = 1'b0;
  logic        CFGIN_n = 1'b0;
  logic        AS_n = 1'b1;
  logic        DS_n = 1'b1;
  logic        RW_n = 1'b1;
  logic [7:0]  A_HIGH = 8'h00;
  logic [5:0]  A_LOW = 6'd0;
  logic [3:0]  D_IN = 4'h0;
  logic [3:0]  D_OUT;
  logic [3:0]  D_OE;
  logic [15:0] BASE;
  logic [1:0]  CONFIGURED_n;
  logic [1:0]  SHUTUP_n;
  logic        CFGOUT_n;
  logic [1:0]  CUR_IDX;

  zorro2_autoconfig_chain dut (
    .C7M          (C7M),
    .RESET_n      (RESET_n),
    .CFGIN_n      (CFGIN_n),
    .AS_n         (AS_n),
    .DS_n         (DS_n),
    .RW_n         (RW_n),
    .A_HIGH       (A_HIGH),
    .A_LOW        (A_LOW),
    .D_IN         (D_IN),
    .D_OUT        (D_OUT),
    .D_OE         (D_OE),
    .BASE         (BASE),
    .CONFIGURED_n (CONFIGURED_n),
    .SHUTUP_n     (SHUTUP_n),
    .CFGOUT_n     (CFGOUT_n),
    .CUR_IDX      (CUR_IDX)
  );

  always #5 C7M = ~C7M;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Board-level model
  // ---------------------------------------------------------------------------
  logic [7:0] m_base [NB];
  bit         m_conf [NB];   // board has been assigned a base
  bit         m_shut [NB];   // board has been shut up
  int         m_ptr;
  bit         m_wait;        // current board done, waiting for AS_n high
  bit         m_fin;         // all boards done, chain passed on
  logic [3:0] m_dout;
  logic       m_acc;
  int         m_off;

  // Expected nibble for board b at byte offset off.
  function automatic logic [3:0] exp_nibble(input int b, input int off);
    int k;
    logic ch;
    logic [15:0] v;
    if (off == 'h00) return {2'b11, LINK[b], ROMV[b]};
    if (off == 'h02) begin
      ch = (b < NB - 1);
      return {ch, SIZE[b]};
    end
    if (off == 'h04) return ~PROD[b][7:4];
    if (off == 'h06) return ~PROD[b][3:0];
    if (off == 'h08) return ~4'b1100;
    if (off == 'h0A) return ~4'b0000;
    if (off >= 'h10 && off <= 'h16) begin
      k = (off - 'h10) / 2;
      return ~4'((MFG >> (12 - 4 * k)) & 16'hF);
    end
    if (off >= 'h18 && off <= 'h26) begin
      k = (off - 'h18) / 2;
      return ~4'((SER >> (28 - 4 * k)) & 32'hF);
    end
    if (off >= 'h28 && off <= 'h2E) begin
      k = (off - 'h28) / 2;
      v = ROMV[b] ? ROMVEC[b] : 16'h0000;
      return ~4'((v >> (12 - 4 * k)) & 16'hF);
    end
    if (off == 'h40 || off == 'h42) return 4'h0;
    return 4'hF;
  endfunction

  assign m_acc = !CFGIN_n && !m_fin && (A_HIGH == 8'hE8) && !AS_n;
  assign m_off = int'(A_LOW) * 2;

  always @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      for (int b = 0; b < NB; b++) begin
        m_base[b] <= 8'h00;
        m_conf[b] <= 1'b0;
        m_shut[b] <= 1'b0;
      end
      m_ptr  <= 0;
      m_wait <= 1'b0;
      m_fin  <= 1'b0;
      m_dout <= 4'hF;
    end else begin
      if (m_acc && RW_n && !DS_n)
        m_dout <= exp_nibble(m_ptr, m_off);
      if (m_acc && !RW_n && !DS_n && !m_conf[m_ptr] && !m_shut[m_ptr]) begin
        if (m_off == 'h4A) m_base[m_ptr][3:0] <= D_IN;
        if (m_off == 'h48) begin
          m_base[m_ptr][7:4] <= D_IN;
          m_conf[m_ptr] <= 1'b1;
          m_wait <= 1'b1;
        end
        if (m_off == 'h4C) begin
          m_shut[m_ptr] <= 1'b1;
          m_wait <= 1'b1;
        end
      end
      if (m_wait && !CFGIN_n && AS_n) begin
        m_wait <= 1'b0;
        if (m_ptr < NB - 1) m_ptr <= m_ptr + 1;
        else m_fin <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge C7M) begin
    if (chk_en) begin
      check("D_OE", D_OE,
            (!CFGIN_n && !m_fin && A_HIGH == 8'hE8 && !AS_n && RW_n && !DS_n)
              ? 4'hF : 4'h0);
      check("D_OUT", D_OUT, m_dout);
      check("BASE", BASE, {m_base[1], m_base[0]});
      check("CONFIGURED_n", CONFIGURED_n, {~m_conf[1], ~m_conf[0]});
      check("SHUTUP_n", SHUTUP_n, {~m_shut[1], ~m_shut[0]});
      check("CFGOUT_n", CFGOUT_n, !m_fin);
      check("CUR_IDX", CUR_IDX, 2'(m_ptr));
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks: inputs change 2 time units after the rising edge
  // ---------------------------------------------------------------------------
  task automatic bus_rd(input logic [5:0] a, output logic [3:0] d,
                        output logic [3:0] oe);
    @(posedge C7M); #2;
    A_HIGH = 8'hE8; A_LOW = a; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
    #2 oe = D_OE;
    @(posedge C7M); #1 d = D_OUT;
    #1 AS_n = 1'b1; DS_n = 1'b1;
    $display("rd  off=%02h d=%h oe=%h idx=%0d", {a, 1'b0}, d, oe, CUR_IDX);
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [3:0] din);
    @(posedge C7M); #2;
    A_HIGH = 8'hE8; A_LOW = a; D_IN = din; RW_n = 1'b0; AS_n = 1'b0; DS_n = 1'b0;
    @(posedge C7M); #2;
    AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    $display("wr  off=%02h d=%h idx=%0d", {a, 1'b0}, din, CUR_IDX);
  endtask

  // Two write edges inside one AS_n assertion.
  task automatic bus_wr2(input logic [5:0] a1, input logic [3:0] d1,
                         input logic [5:0] a2, input logic [3:0] d2);
    @(posedge C7M); #2;
    A_HIGH = 8'hE8; A_LOW = a1; D_IN = d1; RW_n = 1'b0; AS_n = 1'b0; DS_n = 1'b0;
    @(posedge C7M); #2;
    A_LOW = a2; D_IN = d2;
    @(posedge C7M); #2;
    AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1;
    $display("wr2 off=%02h d=%h then off=%02h d=%h", {a1, 1'b0}, d1, {a2, 1'b0}, d2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge C7M);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " BASE"}, BASE, 16'h0000);
    check({tag, " CONFIGURED_n"}, CONFIGURED_n, 2'b11);
    check({tag, " SHUTUP_n"}, SHUTUP_n, 2'b11);
    check({tag, " CFGOUT_n"}, CFGOUT_n, 1'b1);
    check({tag, " CUR_IDX"}, CUR_IDX, 2'd0);
    check({tag, " D_OUT"}, D_OUT, 4'hF);
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge C7M); #2 RESET_n = 1'b0;
    #2 check_reset_values(tag);
    @(posedge C7M); #2 RESET_n = 1'b1;
    $display("rst %s", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  logic [3:0] d, oe;

  initial begin
    repeat (2) @(posedge C7M);
    #2 check_reset_values("por");
    chk_en = 1'b1;
    RESET_n = 1'b1;

    // Board 0 identity reads.
    bus_rd(6'd0, d, oe);  check("b0 rd00", d, 4'hE); check("b0 oe00", oe, 4'hF);
    bus_rd(6'd1, d, oe);  check("b0 rd02", d, 4'h8);
    bus_rd(6'd2, d, oe);  check("b0 rd04", d, 4'hF);
    bus_rd(6'd3, d, oe);  check("b0 rd06", d, 4'h7);
    bus_rd(6'd4, d, oe);  check("b0 rd08", d, 4'h3);
    bus_rd(6'd9, d, oe);  check("b0 rd12", d, 4'h7);
    bus_rd(6'd11, d, oe); check("b0 rd16", d, 4'h3);
    bus_rd(6'd32, d, oe); check("b0 rd40", d, 4'h0);
    bus_rd(6'd50, d, oe); check("b0 rd64", d, 4'hF);
    check("b0 idx", CUR_IDX, 2'd0);
    for (int a = 0; a < 64; a++) bus_rd(6'(a), d, oe);

    // Board 0 configured at $20.
    bus_wr(6'd37, 4'h0);
    bus_wr(6'd36, 4'h2);
    idle(2);
    check("s2 base0", BASE[7:0], 8'h20);
    check("s2 conf", CONFIGURED_n, 2'b10);
    check("s2 idx", CUR_IDX, 2'd1);
    check("s2 cfgout", CFGOUT_n, 1'b1);

    // Board 1 identity reads.
    bus_rd(6'd0, d, oe);  check("b1 rd00", d, 4'hD);
    bus_rd(6'd1, d, oe);  check("b1 rd02", d, 4'h1);
    bus_rd(6'd3, d, oe);  check("b1 rd06", d, 4'h9);
    bus_rd(6'd23, d, oe); check("b1 rd2E", d, 4'hE);
    for (int a = 0; a < 64; a++) bus_rd(6'(a), d, oe);

    // Board 1 configured at $E0; chain passed on.
    bus_wr(6'd37, 4'h0);
    bus_wr(6'd36, 4'hE);
    idle(2);
    check("s3 base1", BASE[15:8], 8'hE0);
    check("s3 conf", CONFIGURED_n, 2'b00);
    check("s3 cfgout", CFGOUT_n, 1'b0);
    check("s3 idx", CUR_IDX, 2'd1);
    bus_rd(6'd0, d, oe);  check("s3 oe after done", oe, 4'h0);
    bus_wr(6'd37, 4'h7);
    idle(1);
    check("s3 base after done", BASE, 16'hE020);

    // Shut-up path for board 0; held repeat write ignored.
    reset_pulse("s4");
    bus_wr2(6'd38, 4'h0, 6'd36, 4'h7);
    check("s4 shut", SHUTUP_n, 2'b10);
    check("s4 base0", BASE[7:0], 8'h00);
    check("s4 conf", CONFIGURED_n, 2'b11);
    idle(2);
    check("s4 idx", CUR_IDX, 2'd1);
    bus_wr(6'd37, 4'h3);
    bus_wr2(6'd36, 4'hA, 6'd36, 4'h5);
    idle(2);
    check("s4 base1", BASE[15:8], 8'hA3);
    check("s4 conf1", CONFIGURED_n, 2'b01);
    check("s4 cfgout", CFGOUT_n, 1'b0);

    // Chain input inactive: nothing happens.
    reset_pulse("s5");
    CFGIN_n = 1'b1;
    bus_rd(6'd0, d, oe);  check("s5 oe", oe, 4'h0); check("s5 dout", d, 4'hF);
    bus_wr(6'd37, 4'h5);
    bus_wr(6'd36, 4'hC);
    idle(2);
    check("s5 base", BASE, 16'h0000);
    check("s5 conf", CONFIGURED_n, 2'b11);
    check("s5 idx", CUR_IDX, 2'd0);
    CFGIN_n = 1'b0;

    // Partial nibble discarded by reset.
    bus_wr(6'd37, 4'h5);
    idle(1);
    check("s6 partial", BASE[7:0], 8'h05);
    reset_pulse("s6");
    check("s6 discard", BASE[7:0], 8'h00);

    // Board 0 configured, then reset returns everything to defaults.
    bus_wr(6'd37, 4'h5);
    bus_wr(6'd36, 4'hC);
    idle(2);
    check("s7 base0", BASE[7:0], 8'hC5);
    check("s7 conf", CONFIGURED_n, 2'b10);
    reset_pulse("s7");
    bus_rd(6'd0, d, oe);  check("s7 first rd", d, 4'hE); check("s7 first oe", oe, 4'hF);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
